// File: rtl/dvp_cam_tx_if.sv
// ---------------------------------------------------------------------------
// dvp_cam_tx_if
// Bundle of every non-clock, non-reset signal of the DVP camera emulator.
//   enable_i                                     frame generation enable
//   pix_red_i / pix_green_i / pix_blue_i         RGB888 pixel offered by the source
//   pix_valid_i                                  source has a pixel ready
//   pix_ready_o                                  one-cycle pull strobe
//   pclk_o / vsync_o / href_o / cam_data_o       DVP bus
//   busy_o / frame_done_o / underrun_o           status
// Modports: slave = the emulator itself, master = the pixel source / observer.
// ---------------------------------------------------------------------------
interface dvp_cam_tx_if;
   logic       enable_i;
   logic [7:0] pix_red_i;
   logic [7:0] pix_green_i;
   logic [7:0] pix_blue_i;
   logic       pix_valid_i;
   logic       pix_ready_o;
   logic       pclk_o;
   logic       vsync_o;
   logic       href_o;
   logic [7:0] cam_data_o;
   logic       busy_o;
   logic       frame_done_o;
   logic       underrun_o;

   modport slave (
      input  enable_i, pix_red_i, pix_green_i, pix_blue_i, pix_valid_i,
      output pix_ready_o, pclk_o, vsync_o, href_o, cam_data_o,
             busy_o, frame_done_o, underrun_o
   );

   modport master (
      output enable_i, pix_red_i, pix_green_i, pix_blue_i, pix_valid_i,
      input  pix_ready_o, pclk_o, vsync_o, href_o, cam_data_o,
             busy_o, frame_done_o, underrun_o
   );
endinterface

// File: rtl/dvp_cam_tx.sv
// ---------------------------------------------------------------------------
// dvp_cam_tx
// Transmit side of a DVP camera bus, used as an on-chip sensor emulator.
// Pulls RGB888 pixels, packs each into two RGB565 bytes and frames them with
// OV-style vsync/href timing. One byte slot = two sys_clk cycles
// (phase 0: pclk low, phase 1: pclk high); bus outputs change only when a
// slot begins.
// Ports:
//   sys_clk_i  system clock (sole clock)
//   sys_rst_i  asynchronous active-high reset
//   bus        dvp_cam_tx_if.slave: enable, pixel pull, DVP bus and status
// ---------------------------------------------------------------------------
module dvp_cam_tx #(
   parameter int H_ACTIVE    = 640,
   parameter int H_BLANK     = 144,
   parameter int V_ACTIVE    = 480,
   parameter int VSYNC_LINES = 3,
   parameter int V_BACK      = 17,
   parameter int V_FRONT     = 10
) (
   input  logic         sys_clk_i,
   input  logic         sys_rst_i,
   dvp_cam_tx_if.slave  bus
);

   localparam int LINE_SLOTS = 2 * H_ACTIVE + H_BLANK;
   localparam int CW         = $clog2(LINE_SLOTS);
   localparam int LM1        = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
   localparam int LM2        = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
   localparam int LMAX       = (LM1 > LM2) ? LM1 : LM2;
   localparam int LW         = (LMAX > 1) ? $clog2(LMAX) : 1;

   // Terminal counts; a zero-sized region never reaches its own terminal.
   localparam logic [CW-1:0] LINE_LAST = CW'(LINE_SLOTS - 1);
   localparam logic [CW-1:0] ACT_LAST  = CW'(2 * H_ACTIVE - 1);
   localparam logic [CW-1:0] HB_LAST   = CW'(H_BLANK - 1);
   localparam logic [LW-1:0] VS_LAST   = LW'(VSYNC_LINES - 1);
   localparam logic [LW-1:0] VB_LAST   = LW'(V_BACK - 1);
   localparam logic [LW-1:0] VA_LAST   = LW'(V_ACTIVE - 1);
   localparam logic [LW-1:0] VF_LAST   = LW'(V_FRONT - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_VSYNC  = 3'd1,
      ST_VBACK  = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_HBLANK = 3'd4,
      ST_VFRONT = 3'd5
   } state_t;

   // Empty vertical regions are skipped at elaboration time.
   localparam state_t ST_AFTER_VS = (V_BACK > 0) ? ST_VBACK : ST_ACTIVE;
   localparam state_t ST_FIRST    = (VSYNC_LINES > 0) ? ST_VSYNC : ST_AFTER_VS;

   function automatic logic [7:0] pack_byte0(input logic [4:0] red_hi, input logic [2:0] green_hi);
      return {red_hi, green_hi};
   endfunction

   function automatic logic [7:0] pack_byte1(input logic [2:0] green_lo, input logic [4:0] blue_hi);
      return {green_lo, blue_hi};
   endfunction

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [LW-1:0]   r_line;
   logic            r_phase;
   logic            r_pclk;
   logic            r_vsync;
   logic            r_href;
   logic [7:0]      r_data;
   logic [7:0]      r_byte1;
   logic            r_pix_ready;
   logic            r_busy;
   logic            r_frame_done;
   logic            r_underrun;

   state_t          w_nxt_state;
   logic [CW-1:0]   w_nxt_cnt;
   logic [LW-1:0]   w_nxt_line;
   logic            w_line_end;
   logic            w_frame_end;
   logic            w_pull;
   logic            w_unused_pix;

   // RGB565 keeps only the upper bits of each colour channel.
   assign w_unused_pix = ^{bus.pix_red_i[2:0], bus.pix_green_i[1:0], bus.pix_blue_i[2:0]};

   assign w_line_end  = (r_state == ST_HBLANK && r_cnt == HB_LAST) ||
                        (r_state == ST_ACTIVE && r_cnt == ACT_LAST && H_BLANK == 0);
   // The current slot is the last one of the frame.
   assign w_frame_end = (r_state == ST_VFRONT && r_cnt == LINE_LAST && r_line == VF_LAST) ||
                        (w_line_end && r_line == VA_LAST && V_FRONT == 0);
   // The slot after this one carries byte0 of a pixel.
   assign w_pull      = (w_nxt_state == ST_ACTIVE) && !w_nxt_cnt[0];

   // Position of the slot that follows the current one.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_cnt   = r_cnt + CW'(1);
      w_nxt_line  = r_line;
      if (w_frame_end) begin
         w_nxt_state = bus.enable_i ? ST_FIRST : ST_IDLE;
         w_nxt_cnt   = '0;
         w_nxt_line  = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_nxt_state = ST_FIRST;
               w_nxt_cnt   = '0;
               w_nxt_line  = '0;
            end
            ST_VSYNC, ST_VBACK, ST_VFRONT: begin
               if (r_cnt != LINE_LAST) begin
                  w_nxt_cnt = r_cnt + CW'(1);
               end else if ((r_state == ST_VSYNC && r_line == VS_LAST) ||
                            (r_state == ST_VBACK && r_line == VB_LAST)) begin
                  w_nxt_cnt   = '0;
                  w_nxt_line  = '0;
                  w_nxt_state = (r_state == ST_VSYNC) ? ST_AFTER_VS : ST_ACTIVE;
               end else begin
                  w_nxt_cnt  = '0;
                  w_nxt_line = r_line + LW'(1);
               end
            end
            ST_ACTIVE, ST_HBLANK: begin
               if (!w_line_end && !(r_state == ST_ACTIVE && r_cnt == ACT_LAST)) begin
                  w_nxt_cnt = r_cnt + CW'(1);
               end else if (!w_line_end) begin
                  w_nxt_cnt   = '0;
                  w_nxt_state = ST_HBLANK;
               end else if (r_line == VA_LAST) begin
                  w_nxt_cnt   = '0;
                  w_nxt_line  = '0;
                  w_nxt_state = ST_VFRONT;
               end else begin
                  w_nxt_cnt   = '0;
                  w_nxt_line  = r_line + LW'(1);
                  w_nxt_state = ST_ACTIVE;
               end
            end
            default: begin
               w_nxt_state = ST_IDLE;
               w_nxt_cnt   = '0;
               w_nxt_line  = '0;
            end
         endcase
      end
   end

   // Frame FSM, slot phase, pixel capture and all registered outputs.
   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_line       <= '0;
         r_phase      <= 1'b0;
         r_pclk       <= 1'b0;
         r_vsync      <= 1'b0;
         r_href       <= 1'b0;
         r_data       <= 8'h00;
         r_byte1      <= 8'h00;
         r_pix_ready  <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_underrun   <= 1'b0;
      end else if (r_state == ST_IDLE && !bus.enable_i) begin
         r_phase      <= 1'b0;
         r_pclk       <= 1'b0;
         r_vsync      <= 1'b0;
         r_href       <= 1'b0;
         r_data       <= 8'h00;
         r_pix_ready  <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else if (r_state != ST_IDLE && !r_phase) begin
         // Second half of a slot: only pclk and the strobes move.
         r_phase      <= 1'b1;
         r_pclk       <= 1'b1;
         r_pix_ready  <= w_pull;
         r_frame_done <= w_frame_end;
      end else begin
         // Slot boundary (or leaving IDLE): advance and present the new slot.
         r_phase      <= 1'b0;
         r_pclk       <= 1'b0;
         r_pix_ready  <= 1'b0;
         r_frame_done <= 1'b0;
         r_state      <= w_nxt_state;
         r_cnt        <= w_nxt_cnt;
         r_line       <= w_nxt_line;
         r_busy       <= (w_nxt_state != ST_IDLE);
         r_vsync      <= (w_nxt_state == ST_VSYNC);
         r_href       <= (w_nxt_state == ST_ACTIVE);
         if (w_pull) begin
            if (r_pix_ready && bus.pix_valid_i) begin
               r_data  <= pack_byte0(bus.pix_red_i[7:3], bus.pix_green_i[7:5]);
               r_byte1 <= pack_byte1(bus.pix_green_i[4:2], bus.pix_blue_i[7:3]);
            end else begin
               // No pixel at the pull: emit a black pixel and flag it.
               r_data     <= 8'h00;
               r_byte1    <= 8'h00;
               r_underrun <= 1'b1;
            end
         end else if (w_nxt_state == ST_ACTIVE) begin
            r_data <= r_byte1;
         end else begin
            r_data <= 8'h00;
         end
      end
   end

   assign bus.pix_ready_o  = r_pix_ready;
   assign bus.pclk_o       = r_pclk;
   assign bus.vsync_o      = r_vsync;
   assign bus.href_o       = r_href;
   assign bus.cam_data_o   = r_data;
   assign bus.busy_o       = r_busy;
   assign bus.frame_done_o = r_frame_done;
   assign bus.underrun_o   = r_underrun;

endmodule

// File: tb/tb_dvp_cam_tx.sv
// ---------------------------------------------------------------------------
// tb_dvp_cam_tx
// Self-checking bench for dvp_cam_tx with a small frame geometry
// (4x3 active, 14 slots per line, 168 cycles per frame). A frame-position
// model derives every output from the cycle offset since frame start.
// ---------------------------------------------------------------------------
module tb_dvp_cam_tx;

   localparam int H     = 4;
   localparam int HB    = 6;
   localparam int VA    = 3;
   localparam int VS    = 1;
   localparam int VB    = 1;
   localparam int VF    = 1;
   localparam int LS    = 2 * H + HB;
   localparam int LINES = VS + VB + VA + VF;
   localparam int FRAME = 2 * LS * LINES;
   localparam int PPF   = H * VA;
   localparam int A0    = VS + VB;

   typedef struct packed {
      logic       pclk;
      logic       vsync;
      logic       href;
      logic       ready;
      logic       busy;
      logic       done;
      logic       underrun;
      logic [7:0] data;
   } out_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   dvp_cam_tx_if u_bus ();

   dvp_cam_tx #(
      .H_ACTIVE(H), .H_BLANK(HB), .V_ACTIVE(VA),
      .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
   ) u_dut (
      .sys_clk_i(clk),
      .sys_rst_i(rst),
      .bus(u_bus)
   );

   always #5 clk = ~clk;

   int          n_pass = 0;
   int          n_total = 0;
   int          cyc = 0;
   int          start_cyc = 0;
   int          nframes = 0;
   bit          chk_en = 1'b0;
   int          feed_idx = 0;
   logic [23:0] pix_tab [64];
   bit          valid_tab [64];
   logic [7:0]  grabbed [4];
   int          n_ready, n_vs, n_href, done_k, n_rise;
   int          vs_rise [4];
   logic        prev_vs;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total = n_total + 1;
      if (act === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: actual %0h required %0h", name, act, exp);
   endtask

   function automatic logic [7:0] b0(input logic [23:0] px);
      return {px[23:19], px[15:13]};
   endfunction

   function automatic logic [7:0] b1(input logic [23:0] px);
      return {px[12:10], px[7:3]};
   endfunction

   // Pixels whose byte0 slot has begun by cycle k.
   function automatic int pulls_done(input int k);
      int kk, s, l, pos, c;
      if (k < 0) return 0;
      if (k >= nframes * FRAME) return nframes * PPF;
      kk = k % FRAME; s = kk / 2; l = s / LS; pos = s % LS;
      if (l < A0) c = 0;
      else if (l >= A0 + VA) c = PPF;
      else if (pos < 2 * H) c = (l - A0) * H + pos / 2 + 1;
      else c = (l - A0 + 1) * H;
      return (k / FRAME) * PPF + c;
   endfunction

   function automatic out_t model(input int k);
      out_t o;
      int kk, s, l, pos, s1, l1, pos1, g, nd;
      o = '0;
      nd = pulls_done(k);
      for (int i = 0; i < nd; i++) if (!valid_tab[6'(i)]) o.underrun = 1'b1;
      if (k >= 0 && k < nframes * FRAME) begin
         kk = k % FRAME; s = kk / 2; l = s / LS; pos = s % LS;
         o.busy  = 1'b1;
         o.pclk  = (kk % 2 == 1);
         o.vsync = (l < VS);
         o.done  = (kk == FRAME - 1);
         if (l >= A0 && l < A0 + VA && pos < 2 * H) begin
            o.href = 1'b1;
            g = (k / FRAME) * PPF + (l - A0) * H + pos / 2;
            if (valid_tab[6'(g)]) o.data = (pos % 2 == 0) ? b0(pix_tab[6'(g)]) : b1(pix_tab[6'(g)]);
         end
         s1 = s + 1; l1 = s1 / LS; pos1 = s1 % LS;
         o.ready = (kk % 2 == 1) && l1 >= A0 && l1 < A0 + VA && pos1 < 2 * H && pos1 % 2 == 0;
      end
      return o;
   endfunction

   function automatic out_t dut_out();
      out_t a;
      a.pclk = u_bus.pclk_o; a.vsync = u_bus.vsync_o; a.href = u_bus.href_o;
      a.ready = u_bus.pix_ready_o; a.busy = u_bus.busy_o; a.done = u_bus.frame_done_o;
      a.underrun = u_bus.underrun_o; a.data = u_bus.cam_data_o;
      return a;
   endfunction

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   // Pixel source: present table entry feed_idx, advance after each pull.
   initial forever begin
      logic rdy;
      @(negedge clk);
      rdy = u_bus.pix_ready_o;
      @(posedge clk);
      #1;
      if (rdy) feed_idx = feed_idx + 1;
      {u_bus.pix_red_i, u_bus.pix_green_i, u_bus.pix_blue_i} = pix_tab[6'(feed_idx)];
      u_bus.pix_valid_i = valid_tab[6'(feed_idx)];
   end

   // Per-cycle comparison against the model plus event counters.
   initial forever begin
      int   k;
      out_t a, e;
      @(negedge clk);
      if (chk_en) begin
         k = cyc - start_cyc;
         a = dut_out();
         e = model(k);
         check($sformatf("cycle %0d {pclk,vs,href,rdy,busy,done,urun,data}", k), 32'(a), 32'(e));
         if (a.ready) n_ready = n_ready + 1;
         if (a.vsync) n_vs = n_vs + 1;
         if (a.href) n_href = n_href + 1;
         if (a.done && done_k < 0) done_k = k;
         if (a.vsync && !prev_vs && n_rise < 4) begin
            vs_rise[n_rise] = k;
            n_rise = n_rise + 1;
         end
         prev_vs = a.vsync;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      chk_en = 1'b0;
      u_bus.enable_i = 1'b0;
      rst = 1'b1;
      feed_idx = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic start_frames(input int nf);
      @(negedge clk);
      u_bus.enable_i = 1'b1;
      @(posedge clk);
      #1;
      start_cyc = cyc; nframes = nf;
      n_ready = 0; n_vs = 0; n_href = 0; done_k = -1; n_rise = 0; prev_vs = 1'b0;
      chk_en = 1'b1;
   endtask

   task automatic wait_k(input int target);
      while (cyc - start_cyc < target) @(negedge clk);
   endtask

   // Capture the first four active bytes at pclk-high cycles.
   task automatic grab4();
      int n = 0;
      @(negedge clk);
      while (!(u_bus.href_o && u_bus.pclk_o) && n < 400) begin
         @(negedge clk);
         n = n + 1;
      end
      check("href found within bound", 32'(n < 400), 32'd1);
      for (int i = 0; i < 4; i++) begin
         grabbed[i] = u_bus.cam_data_o;
         if (i < 3) repeat (2) @(negedge clk);
      end
   endtask

   initial begin
      out_t m;
      for (int i = 0; i < 64; i++) begin
         pix_tab[i]   = {8'(i * 37 + 5), 8'(i * 11 + 3), 8'(i * 91 + 7)};
         valid_tab[i] = 1'b1;
      end
      pix_tab[0] = 24'h123456;
      pix_tab[1] = 24'hFF00FF;
      u_bus.enable_i = 1'b0;
      u_bus.pix_valid_i = 1'b1;
      {u_bus.pix_red_i, u_bus.pix_green_i, u_bus.pix_blue_i} = 24'h000000;

      // Model anchors computed by hand.
      nframes = 1;
      m = model(56);  check("model byte0 of 12/34/56", 32'(m.data), 32'h11);
      m = model(58);  check("model byte1 of 12/34/56", 32'(m.data), 32'hAA);
      m = model(55);  check("model first pull cycle", 32'(m.ready), 32'd1);
      m = model(167); check("model frame_done cycle", 32'(m.done), 32'd1);
      check("model pulls per frame", 32'(pulls_done(167)), 32'd12);

      // Reset and idle.
      repeat (2) @(negedge clk);
      check("outputs during reset", 32'(dut_out()), 32'd0);
      do_reset();
      @(posedge clk); #1;
      start_cyc = cyc; nframes = 0; n_ready = 0; n_rise = 0; done_k = -1; prev_vs = 1'b0;
      chk_en = 1'b1;
      wait_k(100);
      chk_en = 1'b0;
      check("idle pull count", 32'(n_ready), 32'd0);

      // Single frame with timing and packing.
      start_frames(1);
      @(negedge clk); u_bus.enable_i = 1'b0;
      grab4();
      wait_k(FRAME + 6);
      chk_en = 1'b0;
      check("byte 12/34/56 b0", 32'(grabbed[0]), 32'h11);
      check("byte 12/34/56 b1", 32'(grabbed[1]), 32'hAA);
      check("byte FF/00/FF b0", 32'(grabbed[2]), 32'hF8);
      check("byte FF/00/FF b1", 32'(grabbed[3]), 32'h1F);
      check("vsync high cycles", 32'(n_vs), 32'd28);
      check("href high cycles", 32'(n_href), 32'd48);
      check("pull count single", 32'(n_ready), 32'd12);
      check("frame_done offset", 32'(done_k), 32'd167);
      check("busy after frame", 32'(u_bus.busy_o), 32'd0);

      // Underrun on the second pull.
      do_reset();
      valid_tab[1] = 1'b0;
      start_frames(1);
      @(negedge clk); u_bus.enable_i = 1'b0;
      grab4();
      wait_k(FRAME + 6);
      chk_en = 1'b0;
      check("underrun px0 b0", 32'(grabbed[0]), 32'h11);
      check("underrun px0 b1", 32'(grabbed[1]), 32'hAA);
      check("underrun byte3", 32'(grabbed[2]), 32'h00);
      check("underrun byte4", 32'(grabbed[3]), 32'h00);
      check("underrun sticky", 32'(u_bus.underrun_o), 32'd1);
      check("underrun pull count", 32'(n_ready), 32'd12);
      valid_tab[1] = 1'b1;

      // Continuous frames.
      do_reset();
      start_frames(2);
      wait_k(200);
      u_bus.enable_i = 1'b0;
      wait_k(2 * FRAME + 6);
      chk_en = 1'b0;
      check("pull count two frames", 32'(n_ready), 32'd24);
      check("vsync rises", 32'(n_rise), 32'd2);
      check("second vsync offset", 32'(vs_rise[1]), 32'd168);
      check("first frame_done offset", 32'(done_k), 32'd167);

      // Asynchronous reset in the second active line.
      do_reset();
      start_frames(1);
      @(negedge clk); u_bus.enable_i = 1'b0;
      wait_k(89);
      #2;
      chk_en = 1'b0;
      rst = 1'b1;
      #1;
      check("outputs right after async reset", 32'(dut_out()), 32'd0);
      repeat (3) @(negedge clk);
      check("outputs held in reset", 32'(dut_out()), 32'd0);
      feed_idx = 0;
      rst = 1'b0;
      start_frames(1);
      @(negedge clk); u_bus.enable_i = 1'b0;
      wait_k(FRAME + 6);
      chk_en = 1'b0;
      check("restart vsync at offset", 32'(vs_rise[0]), 32'd0);
      check("restart pull count", 32'(n_ready), 32'd12);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
